// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: single-outstanding instruction-memory request/response bus.
interface fetch_redirect_unit_if;
  logic imemReq;
  logic [31:0] imemAddr;
  logic imemGnt;
  logic imemRdValid;
  logic [31:0] imemRdData;
  modport master(output imemReq, imemAddr, input imemGnt, imemRdValid, imemRdData);
  modport slave(input imemReq, imemAddr, output imemGnt, imemRdValid, imemRdData);
endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch PC, imem requests, wrong-path squash and decode delivery.
// Optional branch/squash counters are built when FETCH_STATS_EN is defined.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4,
  parameter int STAT_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic isBranchTaken,
  input logic [31:0] branchPC,
  input logic stall,
  fetch_redirect_unit_if.master imem,
  output logic instValid,
  output logic [31:0] inst,
  output logic [31:0] instPC,
  output logic flush
`ifdef FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0] branchCount,
  output logic [STAT_W-1:0] squashCount
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} fsmState;
  fsmState state, stateNext;
  logic [31:0] pc, pcNext, redirPC, redirPCNext, instNext, instPCNext;
  logic redirPending, redirPendingNext, instValidNext, squash;
  assign imem.imemReq = state == REQ;
  assign imem.imemAddr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      redirPC <= '0;
      redirPending <= 1'b0;
      instValid <= 1'b0;
      inst <= '0;
      instPC <= '0;
      flush <= 1'b0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      redirPC <= redirPCNext;
      redirPending <= redirPendingNext;
      instValid <= instValidNext;
      inst <= instNext;
      instPC <= instPCNext;
      flush <= isBranchTaken;
    end
  // A redirect arriving while a response is in flight diverts to DROP so that response is discarded.
  always_comb begin
    stateNext = state;
    pcNext = pc;
    redirPCNext = redirPC;
    redirPendingNext = redirPending;
    instValidNext = 1'b0;
    instNext = inst;
    instPCNext = instPC;
    squash = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ:
        if (imem.imemGnt) begin
          stateNext = (isBranchTaken || redirPending) ? DROP : WAIT;
          redirPCNext = isBranchTaken ? branchPC : redirPC;
        end else if (isBranchTaken) begin
          redirPCNext = branchPC;
          redirPendingNext = 1'b1;
        end
      WAIT:
        if (imem.imemRdValid && isBranchTaken) begin
          squash = 1'b1;
          pcNext = branchPC;
          stateNext = REQ;
        end else if (imem.imemRdValid) begin
          instValidNext = 1'b1;
          instNext = imem.imemRdData;
          instPCNext = pc;
          pcNext = pc + PC_STEP;
          stateNext = stall ? HOLD : REQ;
        end else if (isBranchTaken) begin
          redirPCNext = branchPC;
          stateNext = DROP;
        end
      DROP: begin
        redirPCNext = isBranchTaken ? branchPC : redirPC;
        if (imem.imemRdValid) begin
          squash = 1'b1;
          pcNext = isBranchTaken ? branchPC : redirPC;
          redirPendingNext = 1'b0;
          stateNext = REQ;
        end
      end
      HOLD: begin
        instValidNext = stall && !isBranchTaken;
        pcNext = isBranchTaken ? branchPC : pc;
        stateNext = (stall && !isBranchTaken) ? HOLD : REQ;
      end
      default: stateNext = IDLE;
    endcase
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      branchCount <= '0;
      squashCount <= '0;
    end else begin
      if (isBranchTaken && !(&branchCount)) branchCount <= branchCount + 1'b1;
      if (squash && !(&squashCount)) squashCount <= squashCount + 1'b1;
    end
`else
  logic [STAT_W-1:0] unusedSquash;
  assign unusedSquash = {STAT_W{squash}};
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed and random fetch traffic checked against a transaction-level model.
module tb_fetch_redirect_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, isBranchTaken = 1'b0, stall = 1'b0;
  logic [31:0] branchPC = '0;
  logic instValid, flush;
  logic [31:0] inst, instPC;
  int vectors = 0, miscompares = 0;
  fetch_redirect_unit_if bus();
`ifdef FETCH_STATS_EN
  logic [15:0] branchCount, squashCount;
  fetch_redirect_unit dut(.clk(clk), .rst_n(rst_n), .isBranchTaken(isBranchTaken), .branchPC(branchPC),
    .stall(stall), .imem(bus), .instValid(instValid), .inst(inst), .instPC(instPC), .flush(flush),
    .branchCount(branchCount), .squashCount(squashCount));
`else
  fetch_redirect_unit dut(.clk(clk), .rst_n(rst_n), .isBranchTaken(isBranchTaken), .branchPC(branchPC),
    .stall(stall), .imem(bus), .instValid(instValid), .inst(inst), .instPC(instPC), .flush(flush));
`endif
  always #5 clk = ~clk;
  // Model: whether fetch has started, a response is in flight (and doomed), or an instruction is parked for decode.
  bit mStarted, mBusy, mDoomed, mHeld, mPend, mValid, mFlush;
  logic [31:0] mPc, mTarget, mInst, mInstPC;
  int mBranches, mSquashes;
  int memDelay = 0, memLat = 1;
  logic [31:0] memData = '0;
  bit spurEn = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit mReq();
    return mStarted && !mBusy && !mHeld;
  endfunction
  task automatic mReset();
    {mStarted, mBusy, mDoomed, mHeld, mPend, mValid, mFlush} = '0;
    mPc = RESET_PC;
    mTarget = '0;
    mInst = '0;
    mInstPC = '0;
    mBranches = 0;
    mSquashes = 0;
    memDelay = 0;
  endtask
  task automatic modelStep(input bit b, input logic [31:0] p, input bit s, input bit g, input bit rv, input logic [31:0] rd);
    bit nv = 1'b0;
    mFlush = b;
    if (b && mBranches < 16'hFFFF) mBranches++;
    if (!mStarted) mStarted = 1'b1;
    else if (mHeld) begin
      if (b) begin mHeld = 1'b0; mPc = p; end
      else if (!s) mHeld = 1'b0;
      else nv = 1'b1;
    end else if (mReq()) begin
      if (g) begin mBusy = 1'b1; mDoomed = b || mPend; if (b) mTarget = p; end
      else if (b) begin mTarget = p; mPend = 1'b1; end
    end else if (mDoomed) begin
      if (b) mTarget = p;
      if (rv) begin
        {mBusy, mDoomed, mPend} = '0;
        mPc = mTarget;
        if (mSquashes < 16'hFFFF) mSquashes++;
      end
    end else if (rv) begin
      mBusy = 1'b0;
      if (b) begin
        mPc = p;
        if (mSquashes < 16'hFFFF) mSquashes++;
      end else begin
        nv = 1'b1;
        mInst = rd;
        mInstPC = mPc;
        mPc = mPc + 32'd4;
        mHeld = s;
      end
    end else if (b) begin
      mDoomed = 1'b1;
      mTarget = p;
    end
    mValid = nv;
  endtask
  task automatic compareAll();
    check("imemReq", {31'b0, bus.imemReq}, {31'b0, mReq()});
    if (mReq()) check("imemAddr", bus.imemAddr, mPc);
    check("instValid", {31'b0, instValid}, {31'b0, mValid});
    if (mValid) begin
      check("inst", inst, mInst);
      check("instPC", instPC, mInstPC);
    end
    check("flush", {31'b0, flush}, {31'b0, mFlush});
`ifdef FETCH_STATS_EN
    check("branchCount", {16'b0, branchCount}, mBranches);
    check("squashCount", {16'b0, squashCount}, mSquashes);
`endif
  endtask
  // Called at a falling edge: drive one cycle of inputs, advance model and memory, check after the next fall.
  task automatic cycle(input bit b, input logic [31:0] p, input bit s, input bit g);
    bit reqNow, rv;
    logic [31:0] rd;
    reqNow = mReq();
    rv = (memDelay == 1) || (spurEn && !mBusy && $urandom_range(15) == 0);
    rd = (memDelay == 1) ? memData : $urandom;
    isBranchTaken = b;
    branchPC = p;
    stall = s;
    bus.imemGnt = g;
    bus.imemRdValid = rv;
    bus.imemRdData = rd;
    @(posedge clk);
    modelStep(b, p, s, g, rv, rd);
    if (rv) memDelay = 0;
    else if (memDelay > 1) memDelay--;
    if (g && reqNow) begin
      memDelay = memLat;
      memData = $urandom;
    end
    @(negedge clk);
    compareAll();
  endtask
  task automatic checkResetValues(input string tag);
    check({tag, ".imemReq"}, {31'b0, bus.imemReq}, 32'd0);
    check({tag, ".imemAddr"}, bus.imemAddr, RESET_PC);
    check({tag, ".instValid"}, {31'b0, instValid}, 32'd0);
    check({tag, ".inst"}, inst, 32'd0);
    check({tag, ".instPC"}, instPC, 32'd0);
    check({tag, ".flush"}, {31'b0, flush}, 32'd0);
  endtask
  initial begin
    logic [31:0] t;
    bus.imemGnt = 1'b0;
    bus.imemRdValid = 1'b0;
    bus.imemRdData = '0;
    mReset();
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    memLat = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    memLat = 2;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    memLat = 1;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h300, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrapAddr", bus.imemAddr, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkResetValues("asyncReset");
    mReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    spurEn = 1'b1;
    repeat (3000) begin
      memLat = $urandom_range(3, 1);
      t = $urandom;
      t[1:0] = 2'b00;
      cycle($urandom_range(7) == 0, t, $urandom_range(3) == 0, $urandom_range(2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
